// File: rtl/i2c_slave_regs_if.sv
// Signal bundle for the I2C target register block: pad-side SCL/SDA with open-drain
// enable, the user register port and the per-byte write notification.
interface i2c_slave_regs_if #(
    parameter int unsigned AW = 4
);
    logic          scl_i;
    logic          sda_i;
    logic          sda_oe;
    logic [AW-1:0] usr_addr;
    logic          usr_we;
    logic [7:0]    usr_wdata;
    logic [7:0]    usr_rdata;
    logic          i2c_busy;
    logic          wr_pulse;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    modport slave (
        input  scl_i, sda_i, usr_addr, usr_we, usr_wdata,
        output sda_oe, usr_rdata, i2c_busy, wr_pulse, wr_addr, wr_data
    );

    modport master (
        output scl_i, sda_i, usr_addr, usr_we, usr_wdata,
        input  sda_oe, usr_rdata, i2c_busy, wr_pulse, wr_addr, wr_data
    );
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C target exposing a 2^AW-byte register file: pointer write, burst write with
// auto-increment, random and current-address reads; SDA is only ever pulled low.
module i2c_slave_regs #(
    parameter logic [6:0]  SLV_ADDR = 7'h48,
    parameter int unsigned AW       = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    i2c_slave_regs_if.slave bus
);
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = 4;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
    } state_e;

    logic scl_s1_q, scl_s2_q, scl_h_q;
    logic sda_s1_q, sda_s2_q, sda_h_q;

    state_e        state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    tx_q, tx_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          rw_q, rw_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          wr_pulse_q, wr_pulse_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    regs_q [DEPTH];
    logic [7:0]    regs_d [DEPTH];

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;

    // Bus conditioning: two-flop synchronizers plus a history flop for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_h_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_h_q  <= 1'b1;
        end else begin
            scl_s1_q <= bus.scl_i;
            scl_s2_q <= scl_s1_q;
            scl_h_q  <= scl_s2_q;
            sda_s1_q <= bus.sda_i;
            sda_s2_q <= sda_s1_q;
            sda_h_q  <= sda_s2_q;
        end
    end

    assign scl_rise  = scl_s2_q & ~scl_h_q;
    assign scl_fall  = ~scl_s2_q & scl_h_q;
    assign start_det = scl_s2_q & sda_h_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & ~sda_h_q & sda_s2_q;
    assign rx_byte   = {shift_q[6:0], sda_s2_q};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= '0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            regs_q     <= '{default: 8'h00};
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            regs_q     <= regs_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        regs_d     = regs_q;

        // User write first so a same-address I2C store below overrides it
        if (bus.usr_we) regs_d[bus.usr_addr] = bus.usr_wdata;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + CW'(1);
                        if (bit_cnt_q == CW'(7)) begin
                            if (state_q == ADDR) begin
                                if (rx_byte[7:1] == SLV_ADDR) begin
                                    rw_d    = rx_byte[0];
                                    busy_d  = 1'b1;
                                    state_d = ADDR_ACK;
                                end else begin
                                    state_d = IDLE;
                                end
                            end else if (state_q == PTR) begin
                                ptr_d   = rx_byte[AW-1:0];
                                state_d = PTR_ACK;
                            end else begin
                                regs_d[ptr_q] = rx_byte;
                                wr_pulse_d    = 1'b1;
                                wr_addr_d     = ptr_q;
                                wr_data_d     = rx_byte;
                                ptr_d         = ptr_q + AW'(1);
                                state_d       = WDATA_ACK;
                            end
                        end
                    end
                end
                // Count 8 marks the fall that starts the ACK clock, 9 the fall that ends it
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == CW'(8)) begin
                            sda_oe_d  = 1'b1;
                            bit_cnt_d = CW'(9);
                        end else begin
                            bit_cnt_d = '0;
                            sda_oe_d  = 1'b0;
                            state_d   = WDATA;
                            if (state_q == ADDR_ACK) begin
                                if (rw_q) begin
                                    tx_d     = regs_q[ptr_q];
                                    sda_oe_d = ~regs_q[ptr_q][7];
                                    state_d  = RDATA;
                                end else begin
                                    state_d = PTR;
                                end
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                        tx_d      = {tx_q[6:0], 1'b0};
                    end else if (scl_fall) begin
                        if (bit_cnt_q == CW'(8)) begin
                            sda_oe_d = 1'b0;
                            ptr_d    = ptr_q + AW'(1);
                            state_d  = RACK;
                        end else begin
                            sda_oe_d = ~tx_q[7];
                        end
                    end
                end
                RACK: begin
                    if (scl_rise && sda_s2_q) begin
                        sda_oe_d = 1'b0;
                        busy_d   = 1'b0;
                        state_d  = IDLE;
                    end else if (scl_fall) begin
                        tx_d      = regs_q[ptr_q];
                        sda_oe_d  = ~regs_q[ptr_q][7];
                        bit_cnt_d = '0;
                        state_d   = RDATA;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.sda_oe    = sda_oe_q;
    assign bus.i2c_busy  = busy_q;
    assign bus.wr_pulse  = wr_pulse_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.usr_rdata = regs_q[bus.usr_addr];
endmodule
